// File: rtl/pe_bfly_pipe.sv
// ML-KEM butterfly processing element: CT / GS / MUL / ADDSUB per beat, NUM_LANES lanes,
// fixed latency MUL_STAGES+2 with a stall-all valid/ready pipeline and a sideband tag.
module pe_bfly_pipe #(
  parameter int COEFF_W    = 12,
  parameter int Q          = 3329,
  parameter int NUM_LANES  = 2,
  parameter int MUL_STAGES = 2,
  parameter int TAG_W      = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic [1:0]                     mode_i,
  input  logic [NUM_LANES*COEFF_W-1:0]   a_i,
  input  logic [NUM_LANES*COEFF_W-1:0]   b_i,
  input  logic [NUM_LANES*COEFF_W-1:0]   w_i,
  input  logic [TAG_W-1:0]               tag_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [NUM_LANES*COEFF_W-1:0]   u_o,
  output logic [NUM_LANES*COEFF_W-1:0]   v_o,
  output logic [TAG_W-1:0]               tag_o
);

  localparam int PW  = 2 * COEFF_W;
  localparam int W1  = COEFF_W + 1;
  localparam int LST = MUL_STAGES - 1;
  localparam logic [W1-1:0] Q_E = W1'(Q);
  localparam logic [PW-1:0] Q_P = PW'(Q);

  localparam logic [1:0] MODE_CT     = 2'd0;
  localparam logic [1:0] MODE_GS     = 2'd1;
  localparam logic [1:0] MODE_ADDSUB = 2'd3;

  function automatic logic [COEFF_W-1:0] add_mod(input logic [COEFF_W-1:0] x, input logic [COEFF_W-1:0] y);
    logic [W1-1:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= Q_E) s = s - Q_E;
    return COEFF_W'(s);
  endfunction

  function automatic logic [COEFF_W-1:0] sub_mod(input logic [COEFF_W-1:0] x, input logic [COEFF_W-1:0] y);
    logic [W1-1:0] s;
    s = {1'b0, x} + Q_E - {1'b0, y};
    if (s >= Q_E) s = s - Q_E;
    return COEFF_W'(s);
  endfunction

  // Halving mod an odd Q: odd sums get Q added first so the shift is exact.
  function automatic logic [COEFF_W-1:0] half_mod(input logic [COEFF_W-1:0] s);
    logic [W1-1:0] t;
    t = s[0] ? ({1'b0, s} + Q_E) : {1'b0, s};
    return COEFF_W'(t >> 1);
  endfunction

  logic advance;
  assign advance    = out_ready_i || !out_valid_o;
  assign in_ready_o = advance;

  logic [COEFF_W-1:0] in_a [NUM_LANES];
  logic [COEFF_W-1:0] in_b [NUM_LANES];
  logic [COEFF_W-1:0] in_w [NUM_LANES];
  logic [COEFF_W-1:0] s0_x_n [NUM_LANES];
  logic [COEFF_W-1:0] s0_w_n [NUM_LANES];
  logic [COEFF_W-1:0] s0_p_n [NUM_LANES];

  logic               s0_valid;
  logic [1:0]         s0_mode;
  logic [TAG_W-1:0]   s0_tag;
  logic [COEFF_W-1:0] s0_x [NUM_LANES];
  logic [COEFF_W-1:0] s0_w [NUM_LANES];
  logic [COEFF_W-1:0] s0_p [NUM_LANES];

  logic               m_valid [MUL_STAGES];
  logic [1:0]         m_mode  [MUL_STAGES];
  logic [TAG_W-1:0]   m_tag   [MUL_STAGES];
  logic [COEFF_W-1:0] m_p     [MUL_STAGES][NUM_LANES];
  logic [PW-1:0]      m_prod  [MUL_STAGES][NUM_LANES];

  logic [COEFF_W-1:0]           red [NUM_LANES];
  logic [COEFF_W-1:0]           t_l [NUM_LANES];
  logic [NUM_LANES*COEFF_W-1:0] u_n;
  logic [NUM_LANES*COEFF_W-1:0] v_n;

  // ADDSUB reuses the multiplier with w=1 so its difference rides the product path.
  always_comb begin
    for (int k = 0; k < NUM_LANES; k++) begin
      in_a[k]   = a_i[k*COEFF_W +: COEFF_W];
      in_b[k]   = b_i[k*COEFF_W +: COEFF_W];
      in_w[k]   = w_i[k*COEFF_W +: COEFF_W];
      s0_x_n[k] = in_b[k];
      s0_w_n[k] = in_w[k];
      s0_p_n[k] = in_a[k];
      case (mode_i)
        MODE_GS: begin
          s0_x_n[k] = sub_mod(in_a[k], in_b[k]);
          s0_p_n[k] = half_mod(add_mod(in_a[k], in_b[k]));
        end
        MODE_ADDSUB: begin
          s0_x_n[k] = sub_mod(in_a[k], in_b[k]);
          s0_w_n[k] = COEFF_W'(1);
          s0_p_n[k] = add_mod(in_a[k], in_b[k]);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_LANES; k++) red[k] = COEFF_W'(m_prod[0][k] % Q_P);
  end

  // With one multiply stage the reduction sits in front of the output stage instead.
  always_comb begin
    u_n = '0;
    v_n = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      t_l[k] = (MUL_STAGES == 1) ? red[k] : COEFF_W'(m_prod[LST][k]);
      u_n[k*COEFF_W +: COEFF_W] = m_p[LST][k];
      v_n[k*COEFF_W +: COEFF_W] = t_l[k];
      if (m_mode[LST] == MODE_CT) begin
        u_n[k*COEFF_W +: COEFF_W] = add_mod(m_p[LST][k], t_l[k]);
        v_n[k*COEFF_W +: COEFF_W] = sub_mod(m_p[LST][k], t_l[k]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0_valid    <= 1'b0;
      s0_mode     <= '0;
      s0_tag      <= '0;
      out_valid_o <= 1'b0;
      u_o         <= '0;
      v_o         <= '0;
      tag_o       <= '0;
      for (int k = 0; k < NUM_LANES; k++) begin
        s0_x[k] <= '0;
        s0_w[k] <= '0;
        s0_p[k] <= '0;
      end
      for (int i = 0; i < MUL_STAGES; i++) begin
        m_valid[i] <= 1'b0;
        m_mode[i]  <= '0;
        m_tag[i]   <= '0;
        for (int k = 0; k < NUM_LANES; k++) begin
          m_p[i][k]    <= '0;
          m_prod[i][k] <= '0;
        end
      end
    end else if (advance) begin
      s0_valid   <= in_valid_i;
      s0_mode    <= mode_i;
      s0_tag     <= tag_i;
      m_valid[0] <= s0_valid;
      m_mode[0]  <= s0_mode;
      m_tag[0]   <= s0_tag;
      for (int k = 0; k < NUM_LANES; k++) begin
        s0_x[k]      <= s0_x_n[k];
        s0_w[k]      <= s0_w_n[k];
        s0_p[k]      <= s0_p_n[k];
        m_p[0][k]    <= s0_p[k];
        m_prod[0][k] <= PW'(s0_x[k]) * PW'(s0_w[k]);
      end
      for (int i = 1; i < MUL_STAGES; i++) begin
        m_valid[i] <= m_valid[i-1];
        m_mode[i]  <= m_mode[i-1];
        m_tag[i]   <= m_tag[i-1];
        for (int k = 0; k < NUM_LANES; k++) begin
          m_p[i][k]    <= m_p[i-1][k];
          m_prod[i][k] <= (i == 1) ? PW'(red[k]) : m_prod[i-1][k];
        end
      end
      out_valid_o <= m_valid[LST];
      tag_o       <= m_tag[LST];
      u_o         <= u_n;
      v_o         <= v_n;
    end
  end

endmodule

// File: tb/tb_pe_bfly_pipe.sv
// Directed bench for pe_bfly_pipe: per-mode vectors, back-to-back modes, backpressure, mid-flight reset.
module tb_pe_bfly_pipe;
  localparam int W  = 12;
  localparam int L  = 2;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [1:0]    mode_i;
  logic [L*W-1:0] a_i, b_i, w_i;
  logic [TW-1:0] tag_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [L*W-1:0] u_o, v_o;
  logic [TW-1:0] tag_o;

  int checks   = 0;
  int failures = 0;

  pe_bfly_pipe dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .mode_i(mode_i), .a_i(a_i), .b_i(b_i), .w_i(w_i), .tag_i(tag_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .u_o(u_o), .v_o(v_o), .tag_o(tag_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [TW-1:0]  tag;
    logic [L*W-1:0] u;
    logic [L*W-1:0] v;
  } exp_t;

  function automatic logic [L*W-1:0] pk(input int l1, input int l0);
    return {W'(l1), W'(l0)};
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
    end
  endtask

  task automatic run_single(input logic [1:0] m, input int a0, input int b0, input int w0,
                            input int a1, input int b1, input int w1, input logic [TW-1:0] tg,
                            input int eu0, input int ev0, input int eu1, input int ev1);
    int n;
    check("idle_ready", 64'(in_ready_o), 64'd1);
    mode_i = m; a_i = pk(a1, a0); b_i = pk(b1, b0); w_i = pk(w1, w0);
    tag_i = tg; in_valid_i = 1'b1; out_ready_i = 1'b1;
    @(negedge clk);
    in_valid_i = 1'b0;
    n = 1;
    while (!out_valid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("latency", 64'(n), 64'd4);
    check("tag", 64'(tag_o), 64'(tg));
    check("u", 64'(u_o), 64'(pk(eu1, eu0)));
    check("v", 64'(v_o), 64'(pk(ev1, ev0)));
    @(negedge clk);
    check("drained", 64'(out_valid_o), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t q[$];
    exp_t e;
    exp_t bb [4];
    logic [L*W-1:0] fu, fv;
    logic [TW-1:0]  ft;
    logic frz, acc;
    int idx, popped, c, stalls, n;

    rst = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    mode_i = '0; a_i = '0; b_i = '0; w_i = '0; tag_i = '0;
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(out_valid_o), 64'd0);
    check("rst_u", 64'(u_o), 64'd0);
    check("rst_v", 64'(v_o), 64'd0);
    check("rst_tag", 64'(tag_o), 64'd0);
    check("rst_ready", 64'(in_ready_o), 64'd1);
    rst = 1'b1;
    @(negedge clk);

    run_single(2'd0, 100, 2, 17, 3000, 1, 1000, 8'hA1, 134, 66, 671, 2000);
    run_single(2'd1, 3, 4, 5, 3328, 3328, 7, 8'hA2, 1668, 3324, 3328, 0);
    run_single(2'd1, 0, 0, 7, 1, 0, 2, 8'hA3, 0, 0, 1665, 2);
    run_single(2'd2, 55, 3328, 3328, 7, 10, 20, 8'hA4, 55, 1, 7, 200);
    run_single(2'd3, 0, 1, 9, 3328, 1, 4, 8'hA5, 1, 3328, 0, 3327);

    // back-to-back, modes 0..3
    bb[0] = '{tag: 8'h10, u: pk(134, 134),   v: pk(66, 66)};
    bb[1] = '{tag: 8'h11, u: pk(1668, 1668), v: pk(3324, 3324)};
    bb[2] = '{tag: 8'h12, u: pk(55, 55),     v: pk(1, 1)};
    bb[3] = '{tag: 8'h13, u: pk(1, 1),       v: pk(3328, 3328)};
    out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mode_i = 2'(i); tag_i = 8'h10 + 8'(i); in_valid_i = 1'b1;
      case (i)
        0: begin a_i = pk(100, 100); b_i = pk(2, 2);       w_i = pk(17, 17);     end
        1: begin a_i = pk(3, 3);     b_i = pk(4, 4);       w_i = pk(5, 5);       end
        2: begin a_i = pk(55, 55);   b_i = pk(3328, 3328); w_i = pk(3328, 3328); end
        default: begin a_i = pk(0, 0); b_i = pk(1, 1);     w_i = pk(9, 9);       end
      endcase
      #1;
      check("b2b_ready", 64'(in_ready_o), 64'd1);
      @(negedge clk);
    end
    in_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("b2b_valid", 64'(out_valid_o), 64'd1);
      check("b2b_tag", 64'(tag_o), 64'(bb[i].tag));
      check("b2b_u", 64'(u_o), 64'(bb[i].u));
      check("b2b_v", 64'(v_o), 64'(bb[i].v));
      @(negedge clk);
    end
    check("b2b_after", 64'(out_valid_o), 64'd0);

    // 8-beat stream with a 3-cycle downstream stall
    idx = 0; popped = 0; c = 0; stalls = 0; frz = 1'b0;
    fu = '0; fv = '0; ft = '0;
    while (popped < 8 && c < 60) begin
      out_ready_i = !(c >= 6 && c < 9);
      if (idx < 8) begin
        in_valid_i = 1'b1;
        tag_i = 8'h20 + 8'(idx);
        if (idx % 2 == 0) begin
          mode_i = 2'd3; a_i = pk(100 + idx, 100 + idx); b_i = pk(idx, idx); w_i = pk(9, 9);
        end else begin
          mode_i = 2'd2; a_i = pk(idx, idx); b_i = pk(idx, idx); w_i = pk(2, 2);
        end
      end else begin
        in_valid_i = 1'b0;
      end
      #1;
      if (frz) begin
        check("frozen_u", 64'(u_o), 64'(fu));
        check("frozen_v", 64'(v_o), 64'(fv));
        check("frozen_tag", 64'(tag_o), 64'(ft));
      end
      if (out_valid_o && !out_ready_i) begin
        check("stall_ready", 64'(in_ready_o), 64'd0);
        fu = u_o; fv = v_o; ft = tag_o; frz = 1'b1; stalls++;
      end else begin
        frz = 1'b0;
      end
      if (out_valid_o && out_ready_i) begin
        if (q.size() > 0) begin
          e = q.pop_front();
          check("bp_tag", 64'(tag_o), 64'(e.tag));
          check("bp_u", 64'(u_o), 64'(e.u));
          check("bp_v", 64'(v_o), 64'(e.v));
        end else begin
          check("bp_unexpected_beat", 64'(tag_o), 64'hFFFF);
        end
        popped++;
      end
      acc = in_valid_i && in_ready_o;
      if (acc) begin
        e.tag = 8'h20 + 8'(idx);
        if (idx % 2 == 0) begin
          e.u = pk(100 + 2*idx, 100 + 2*idx); e.v = pk(100, 100);
        end else begin
          e.u = pk(idx, idx); e.v = pk(2*idx, 2*idx);
        end
        q.push_back(e);
      end
      @(negedge clk);
      if (acc) idx++;
      c++;
    end
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    check("bp_popped", 64'(popped), 64'd8);
    check("bp_accepted", 64'(idx), 64'd8);
    check("bp_stalls", 64'(stalls), 64'd3);

    // reset with three beats in flight
    for (int i = 0; i < 3; i++) begin
      mode_i = 2'd0; tag_i = 8'h40 + 8'(i); in_valid_i = 1'b1;
      a_i = pk(100, 100); b_i = pk(2, 2); w_i = pk(17, 17);
      @(negedge clk);
    end
    in_valid_i = 1'b0; out_ready_i = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", 64'(out_valid_o), 64'd1);
    check("pre_rst_u", 64'(u_o), 64'(pk(134, 134)));
    rst = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid_o), 64'd0);
    check("mid_rst_u", 64'(u_o), 64'd0);
    check("mid_rst_v", 64'(v_o), 64'd0);
    check("mid_rst_tag", 64'(tag_o), 64'd0);
    @(negedge clk);
    rst = 1'b1; out_ready_i = 1'b1;
    @(negedge clk);
    run_single(2'd0, 3000, 1, 1000, 100, 2, 17, 8'h55, 671, 2000, 134, 66);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid_o) n++;
      @(negedge clk);
    end
    check("no_stale", 64'(n), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
